eeprom_access_sched: RTL and testbench

//  Schedules all EEPROM (24C02-class, I2C) traffic for the stopwatch design. Two requesters share one byte-level
//  I2C master: a write port used by the play/stop key logic when a stored value is saved or cleared while stopped,
//  and a read port used at power-up restore. The block arbitrates, sequences each transfer, enforces the EEPROM

---
 rtl/eeprom_sched_pkg.sv | 15 +
 rtl/eeprom_access_sched_if.sv | 16 +
 rtl/eeprom_access_sched_twr_timer.sv | 19 +
 rtl/eeprom_access_sched.sv | 111 +++++++++++
 tb/tb_eeprom_access_sched.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/eeprom_sched_pkg.sv
// eeprom_sched_pkg: shared state encoding, transfer direction codes and tWR cycle derivation.
// States VERIFY_ISSUE/VERIFY_WAIT exist only when EEPROM_VERIFY_EN is defined.
package eeprom_sched_pkg;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_TWR, S_RETRY_GAP, S_DONE
`ifdef EEPROM_VERIFY_EN
      , S_VERIFY_ISSUE, S_VERIFY_WAIT
`endif
   } state_t;
   function automatic int twr_cyc(input int clk_hz, input int twr_us);
      return clk_hz / 1_000_000 * twr_us;
   endfunction
endpackage

// File: rtl/eeprom_access_sched_if.sv
// eeprom_access_sched_if: requester ports and byte-level I2C master handshake of the EEPROM scheduler.
// slave = the scheduler itself, master = the requesters/I2C master side.
interface eeprom_access_sched_if;
   logic       wr_req, wr_ack, rd_req, rd_valid, busy, err;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   logic       i2c_start, i2c_rw, i2c_done, i2c_nack;
   logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_rdata, i2c_done, i2c_nack,
      output wr_ack, rd_data, rd_valid, busy, err, i2c_start, i2c_rw, i2c_addr, i2c_wdata
   );
   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_rdata, i2c_done, i2c_nack,
      input  wr_ack, rd_data, rd_valid, busy, err, i2c_start, i2c_rw, i2c_addr, i2c_wdata
   );
endinterface

// File: rtl/eeprom_access_sched_twr_timer.sv
// twr_timer: wait counter shared by the write-cycle wait and the NACK retry gap.
// Held clear while load is high; expire marks the CYC-th counting cycle.
module twr_timer #(
   parameter int CYC = 20
) (
   input  logic sclk,
   input  logic nrst,
   input  logic load,
   input  logic count,
   output logic expire
);
   localparam int W = $clog2(CYC + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge sclk or negedge nrst)
      if (!nrst) cnt <= '0;
      else if (load) cnt <= '0;
      else if (count) cnt <= cnt + 1'b1;
   assign expire = count && cnt == W'(CYC - 1);
endmodule

// File: rtl/eeprom_access_sched.sv
// eeprom_access_sched: arbitrates write/read requesters onto one I2C byte master with tWR wait and NACK retry.
// Optional EEPROM_VERIFY_EN: read back every written byte after tWR and flag a mismatch with err.
module eeprom_access_sched import eeprom_sched_pkg::*; #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TWR_US    = 5000,
   parameter int MAX_RETRY = 3
) (
   input logic sclk,
   input logic nrst,
   eeprom_access_sched_if.slave bus
);
   localparam int TWR_CYC = twr_cyc(CLK_HZ, TWR_US);
   localparam int RTW = $clog2(MAX_RETRY + 1) + 1;
   state_t state;
   logic [RTW-1:0] retry;
   logic rr_rd, op_rd, grant_rd, tmr_run, tmr_exp;
   assign grant_rd = bus.rd_req && (!bus.wr_req || rr_rd);
   assign tmr_run = state == S_TWR || state == S_RETRY_GAP;
   twr_timer #(.CYC(TWR_CYC)) u_tmr (
      .sclk(sclk), .nrst(nrst), .load(!tmr_run), .count(tmr_run), .expire(tmr_exp)
   );
   always_ff @(posedge sclk or negedge nrst)
      if (!nrst) begin
         state         <= S_IDLE;
         retry         <= '0;
         rr_rd         <= 1'b1;
         op_rd         <= 1'b0;
         bus.wr_ack    <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.busy      <= 1'b0;
         bus.err       <= 1'b0;
         bus.i2c_start <= 1'b0;
         bus.i2c_rw    <= RW_WRITE;
         bus.i2c_addr  <= '0;
         bus.i2c_wdata <= '0;
      end else begin
         bus.i2c_start <= 1'b0;
         bus.wr_ack    <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.err       <= 1'b0;
         case (state)
            S_IDLE: if (bus.wr_req || bus.rd_req) begin
               state         <= S_ISSUE;
               bus.busy      <= 1'b1;
               bus.i2c_start <= 1'b1;
               op_rd         <= grant_rd;
               bus.i2c_rw    <= grant_rd ? RW_READ : RW_WRITE;
               bus.i2c_addr  <= grant_rd ? bus.rd_addr : bus.wr_addr;
               if (!grant_rd) bus.i2c_wdata <= bus.wr_data;
               // pointer only moves when both sides contend, so a lone grant keeps fairness order
               if (bus.wr_req && bus.rd_req) rr_rd <= !rr_rd;
            end
            S_ISSUE: state <= S_WAIT;
`ifdef EEPROM_VERIFY_EN
            S_VERIFY_ISSUE: state <= S_VERIFY_WAIT;
            S_WAIT, S_VERIFY_WAIT: if (bus.i2c_done) begin
`else
            S_WAIT: if (bus.i2c_done) begin
`endif
               if (bus.i2c_nack) begin
                  if (retry == RTW'(MAX_RETRY)) begin
                     state        <= S_DONE;
                     bus.rd_valid <= op_rd;
                     bus.wr_ack   <= !op_rd;
                     bus.err      <= 1'b1;
                  end else begin
                     retry <= retry + 1'b1;
                     state <= S_RETRY_GAP;
                  end
               end else if (op_rd) begin
                  state        <= S_DONE;
                  bus.rd_data  <= bus.i2c_rdata;
                  bus.rd_valid <= 1'b1;
               end else if (bus.i2c_rw == RW_WRITE) begin
                  state <= S_TWR;
               end else begin
                  state      <= S_DONE;
                  bus.wr_ack <= 1'b1;
                  bus.err    <= bus.i2c_rdata != bus.i2c_wdata;
               end
            end
            S_TWR: if (tmr_exp) begin
`ifdef EEPROM_VERIFY_EN
               state         <= S_VERIFY_ISSUE;
               bus.i2c_start <= 1'b1;
               bus.i2c_rw    <= RW_READ;
               retry         <= '0;
`else
               state      <= S_DONE;
               bus.wr_ack <= 1'b1;
`endif
            end
            S_RETRY_GAP: if (tmr_exp) begin
               bus.i2c_start <= 1'b1;
`ifdef EEPROM_VERIFY_EN
               // a write transfer already switched to read is the readback phase
               state <= (!op_rd && bus.i2c_rw == RW_READ) ? S_VERIFY_ISSUE : S_ISSUE;
`else
               state <= S_ISSUE;
`endif
            end
            S_DONE: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
               retry    <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_eeprom_access_sched.sv
// tb_eeprom_access_sched: timeline model of each transfer fills per-cycle expectations and master responses;
// one negedge process compares every DUT output each cycle.
module tb_eeprom_access_sched;
   localparam int N = 400, TWR = 20, MAXR = 3;
   logic sclk = 1'b0, nrst = 1'b0;
   always #5 sclk = ~sclk;
   eeprom_access_sched_if bus ();
   eeprom_access_sched #(.CLK_HZ(1_000_000), .TWR_US(20), .MAX_RETRY(MAXR)) dut (
      .sclk(sclk), .nrst(nrst), .bus(bus)
   );
   logic       s_nrst[N], s_wreq[N], s_rreq[N], m_done[N], m_nack[N];
   logic [7:0] s_waddr[N], s_wdata[N], s_raddr[N], m_rdata[N];
   logic       e_start[N], e_ack[N], e_valid[N], e_err[N], e_busy[N], e_bus[N], e_cw[N], e_rw[N];
   logic [7:0] e_addr[N], e_wdata[N], e_rdata[N];
`ifdef EEPROM_VERIFY_EN
   logic [7:0] vflip = 8'h00;
`endif
   int vec = 0, bad = 0, cyc = 0, pin2 = -1;
   bit run = 1'b0;

   task automatic chk(input string n, input int c, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s cyc %0d: got %0h want %0h", n, c, act, exp);
      end
   endtask

   task automatic fill_rd(input int k, input logic [7:0] v);
      for (int c = k; c < N; c++) e_rdata[c] = v;
   endtask

   task automatic bus_win(input int s, input int d, input logic rw, input logic [7:0] a,
                          input logic [7:0] wd, input logic cw);
      for (int c = s; c <= d; c++) begin
         e_bus[c] = 1'b1; e_rw[c] = rw; e_addr[c] = a; e_wdata[c] = wd; e_cw[c] = cw;
      end
   endtask

   // q: request raised, r: idle cycle in which it is granted; k returns the ack/valid cycle
   task automatic xfer(input bit rd, input int q, input int r, input logic [7:0] a, input logic [7:0] wd,
                       input int nn, input int lat, input logic [7:0] rdv, input bit hold, output int k);
      int s, d;
      bit e;
      s = r + 1;
      d = s;
      e = 1'b0;
      for (int t = 0; t <= MAXR; t++) begin
         d = s + lat;
         bus_win(s, d, rd, a, wd, !rd);
         e_start[s] = 1'b1;
         m_done[d] = 1'b1;
         if (t < nn) begin
            m_nack[d] = 1'b1;
            if (t == MAXR) e = 1'b1;
            else s = d + TWR + 1;
         end else begin
            m_rdata[d] = rdv;
            break;
         end
      end
      k = d + 1;
      if (!rd && !e) begin
         k = d + TWR + 1;
`ifdef EEPROM_VERIFY_EN
         s = k;
         d = s + lat;
         bus_win(s, d, 1'b1, a, wd, 1'b1);
         e_start[s] = 1'b1;
         m_done[d] = 1'b1;
         m_rdata[d] = wd ^ vflip;
         e = vflip != 8'h00;
         k = d + 1;
`endif
      end
      if (rd && !e) fill_rd(k, rdv);
      for (int c = r + 1; c <= k; c++) e_busy[c] = 1'b1;
      if (rd) e_valid[k] = 1'b1; else e_ack[k] = 1'b1;
      e_err[k] = e;
      for (int c = q; c <= (hold ? k : r); c++) if (rd) s_rreq[c] = 1'b1; else s_wreq[c] = 1'b1;
      for (int c = q; c <= k; c++) begin
         if (rd) s_raddr[c] = c <= r ? a : ~a;
         else begin s_waddr[c] = c <= r ? a : ~a; s_wdata[c] = c <= r ? wd : ~wd; end
      end
   endtask

   task automatic plan();
      int k, kr, kw, r, rc;
      for (int c = 0; c < N; c++) begin
         s_nrst[c] = c >= 3; s_wreq[c] = 0; s_rreq[c] = 0; m_done[c] = 0; m_nack[c] = 0;
         s_waddr[c] = 0; s_wdata[c] = 0; s_raddr[c] = 0; m_rdata[c] = 8'hEE;
         e_start[c] = 0; e_ack[c] = 0; e_valid[c] = 0; e_err[c] = 0; e_busy[c] = 0;
         e_bus[c] = 0; e_cw[c] = 0; e_rw[c] = 0; e_addr[c] = 0; e_wdata[c] = 0; e_rdata[c] = 0;
      end
      xfer(0, 5, 5, 8'h10, 8'hA5, 0, 3, 8'h00, 1, k);
`ifdef EEPROM_VERIFY_EN
      chk("t1_ack_cycle", -1, k, 34);
`else
      chk("t1_ack_cycle", -1, k, 30);
`endif
      m_done[k + 3] = 1'b1;
      m_nack[k + 3] = 1'b1;
      r = k + 6;
      xfer(1, r, r, 8'h10, 8'h00, 0, 3, 8'h3C, 0, k);
      chk("t2_latency", -1, k - r, 5);
      pin2 = k + 1;
      r = k + 4;
      xfer(1, r, r, 8'h20, 8'h00, 0, 2, 8'h77, 1, kr);
      xfer(0, r, kr + 1, 8'h21, 8'h5C, 0, 2, 8'h00, 1, kw);
      chk("t3_read_first", -1, kr < kw, 1);
      r = kw + 4;
      xfer(0, r, r, 8'h22, 8'h96, 0, 2, 8'h00, 1, kw);
      xfer(1, r, kw + 1, 8'h23, 8'h00, 0, 2, 8'hC3, 1, kr);
      chk("t3_write_first", -1, kw < kr, 1);
      r = kr + 4;
      xfer(0, r, r, 8'h30, 8'h11, 4, 3, 8'h00, 1, k);
      chk("t4_abandon_cycle", -1, k - r, 77);
      r = k + 4;
      xfer(1, r, r, 8'h31, 8'h00, 3, 3, 8'h5A, 1, k);
      chk("t4b_retry_ok_cycle", -1, k - r, 77);
`ifdef EEPROM_VERIFY_EN
      r = k + 4;
      vflip = 8'hFF;
      xfer(0, r, r, 8'h40, 8'hA5, 0, 3, 8'h00, 1, k);
      vflip = 8'h00;
      chk("t5_verify_cycle", -1, k - r, 29);
`endif
      r = k + 4;
      rc = r + 4;
      for (int c = r; c < rc; c++) begin s_rreq[c] = 1'b1; s_raddr[c] = 8'h50; end
      e_start[r + 1] = 1'b1;
      bus_win(r + 1, rc - 1, 1'b1, 8'h50, 8'h00, 1'b0);
      for (int c = r + 1; c < rc; c++) e_busy[c] = 1'b1;
      for (int c = rc; c < rc + 3; c++) s_nrst[c] = 1'b0;
      fill_rd(rc, 8'h00);
      r = rc + 5;
      xfer(1, r, r, 8'h51, 8'h00, 0, 1, 8'h81, 1, k);
      chk("t6_min_latency", -1, k - r, 3);
   endtask

   always @(negedge sclk) if (run) begin
      chk("i2c_start", cyc, bus.i2c_start, e_start[cyc]);
      chk("wr_ack", cyc, bus.wr_ack, e_ack[cyc]);
      chk("rd_valid", cyc, bus.rd_valid, e_valid[cyc]);
      chk("err", cyc, bus.err, e_err[cyc]);
      chk("busy", cyc, bus.busy, e_busy[cyc]);
      chk("rd_data", cyc, bus.rd_data, e_rdata[cyc]);
      if (e_bus[cyc]) begin
         chk("i2c_rw", cyc, bus.i2c_rw, e_rw[cyc]);
         chk("i2c_addr", cyc, bus.i2c_addr, e_addr[cyc]);
         if (e_cw[cyc]) chk("i2c_wdata", cyc, bus.i2c_wdata, e_wdata[cyc]);
      end
      if (cyc == pin2) chk("t2_rd_data_3c", cyc, bus.rd_data, 8'h3C);
   end

   initial begin
      plan();
      for (int c = 0; c < N; c++) begin
         cyc = c;
         nrst = s_nrst[c];
         bus.wr_req = s_wreq[c];
         bus.wr_addr = s_waddr[c];
         bus.wr_data = s_wdata[c];
         bus.rd_req = s_rreq[c];
         bus.rd_addr = s_raddr[c];
         bus.i2c_done = m_done[c];
         bus.i2c_nack = m_nack[c];
         bus.i2c_rdata = m_rdata[c];
         run = 1'b1;
         @(posedge sclk);
         #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
